// File: rtl/car_detect_cond_if.sv
// rtl/car_detect_cond_if.sv - signal bundle between the loop conditioner and its controller side
// Purpose: groups the conditioner's sensor input, controller light state and
//          conditioned outputs into one bundle; clk and clr_n stay outside.
// Signals:
//   loop_raw  raw loop detector level (asynchronous to clk, may bounce)
//   cntry     country light state: 0=RED 1=YELLOW 2=GREEN 3=not GREEN
//   x         registered demand bit for the controller
//   fault     loop stuck-on flag
//   car_cnt   saturating count of debounced vehicle arrivals
// Modports: master drives loop_raw/cntry, slave (the conditioner) drives x/fault/car_cnt.
interface car_detect_cond_if #(
  parameter int CW = 8
) ();
  logic          loop_raw;
  logic [1:0]    cntry;
  logic          x;
  logic          fault;
  logic [CW-1:0] car_cnt;

  modport master (output loop_raw, output cntry, input x, input fault, input car_cnt);
  modport slave  (input loop_raw, input cntry, output x, output fault, output car_cnt);
endinterface

// File: rtl/car_detect_cond.sv
// rtl/car_detect_cond.sv - country-road loop conditioner producing the demand bit x
// Purpose: synchronises and debounces the loop sensor, latches demand until the
//          country road is served, limits service with gap and max-green timers,
//          flags a stuck-on loop and counts vehicle arrivals.
// Ports:
//   clk    system clock, all flops on posedge
//   clr_n  asynchronous active-low reset
//   bus    car_detect_cond_if.slave: loop_raw, cntry in; x, fault, car_cnt out
module car_detect_cond #(
  parameter int DEB_CYCLES   = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int MAX_GREEN    = 32,
  parameter int STUCK_CYCLES = 256,
  parameter int CW           = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  car_detect_cond_if.slave  bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int MW = $clog2(MAX_GREEN + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LIM  = DW'(DEB_CYCLES);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP_CYCLES);
  localparam logic [MW-1:0] GRN_LAST = MW'(MAX_GREEN - 1);
  localparam logic [SW-1:0] STK_LIM  = SW'(STUCK_CYCLES);
  localparam logic [1:0]    GREEN    = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_REQ     = 4'b0010,
    ST_SERVE   = 4'b0100,
    ST_RELEASE = 4'b1000
  } state_t;

  logic          s1_q, s2_q;
  logic          det_q, det_d, det_dly_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [SW-1:0] stk_q, stk_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] car_cnt_q, car_cnt_d;
  logic          det_rise;

  state_t        state_q;
  logic          x_q;
  logic [GW-1:0] gap_q, gap_nxt;
  logic [MW-1:0] grn_q;

  always_comb begin
    // Debounce: det only flips after DEB_CYCLES+1 consecutive disagreeing samples.
    det_d     = det_q;
    deb_cnt_d = '0;
    if (s2_q != det_q) begin
      if (deb_cnt_q == DEB_LIM) begin
        det_d = ~det_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    det_rise  = det_q & ~det_dly_q;
    car_cnt_d = car_cnt_q;
    if (det_rise && (car_cnt_q != '1)) begin
      car_cnt_d = car_cnt_q + 1'b1;
    end

    // Stuck-on run length saturates; fault follows it and drops once det is low.
    stk_d   = '0;
    fault_d = 1'b0;
    if (det_q) begin
      stk_d   = (stk_q == STK_LIM) ? stk_q : stk_q + 1'b1;
      fault_d = (stk_d == STK_LIM);
    end

    // A stuck loop must not keep the green alive, so fault blocks the gap reload.
    gap_nxt = (det_q && !fault_q) ? GAP_LD : gap_q - 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      det_q     <= 1'b0;
      det_dly_q <= 1'b0;
      deb_cnt_q <= '0;
      stk_q     <= '0;
      fault_q   <= 1'b0;
      car_cnt_q <= '0;
    end else begin
      s1_q      <= bus.loop_raw;
      s2_q      <= s1_q;
      det_q     <= det_d;
      det_dly_q <= det_q;
      deb_cnt_q <= deb_cnt_d;
      stk_q     <= stk_d;
      fault_q   <= fault_d;
      car_cnt_q <= car_cnt_d;
    end
  end

  // Gap expiry is judged on the decremented value, max green on cycles already served.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      x_q     <= 1'b0;
      gap_q   <= '0;
      grn_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (det_q || fault_q) begin
            state_q <= ST_REQ;
            x_q     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.cntry == GREEN) begin
            state_q <= ST_SERVE;
            gap_q   <= GAP_LD;
            grn_q   <= '0;
          end
        end
        ST_SERVE: begin
          if ((bus.cntry != GREEN) || (grn_q == GRN_LAST) || (gap_nxt == '0)) begin
            state_q <= ST_RELEASE;
            x_q     <= 1'b0;
          end else begin
            grn_q <= grn_q + 1'b1;
            gap_q <= gap_nxt;
          end
        end
        ST_RELEASE: begin
          if (bus.cntry != GREEN) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          x_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x       = x_q;
  assign bus.fault   = fault_q;
  assign bus.car_cnt = car_cnt_q;

endmodule

// File: tb/tb_car_detect_cond.sv
// tb/tb_car_detect_cond.sv - self-checking bench for car_detect_cond
module tb_car_detect_cond;
  localparam int DEB   = 4;
  localparam int GAP   = 8;
  localparam int MAXG  = 32;
  localparam int STUCK = 256;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  car_detect_cond_if #(.CW(8)) bus ();
  car_detect_cond_if #(.CW(2)) bus2 ();
  assign bus2.loop_raw = bus.loop_raw;
  assign bus2.cntry    = bus.cntry;

  car_detect_cond #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP), .MAX_GREEN(MAXG),
                    .STUCK_CYCLES(STUCK), .CW(8)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
  car_detect_cond #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP), .MAX_GREEN(MAXG),
                    .STUCK_CYCLES(STUCK), .CW(2)) dut2 (.clk(clk), .clr_n(clr_n), .bus(bus2));

  int checks   = 0;
  int failures = 0;

  // Reference model: sensor pipeline, disagreement run, high run, arrivals, service mode.
  int m_s1, m_s2, m_det, m_prev, m_run, m_high, m_arr, m_mode, m_grn, m_gap;
  bit m_fault;

  wire [11:0] dut_vec = {bus.x, bus.fault, bus.car_cnt, bus2.car_cnt};

  function automatic logic [11:0] exp_vec();
    logic       ex;
    logic [7:0] c8;
    logic [1:0] c2;
    ex = (m_mode == 1) || (m_mode == 2);
    c8 = (m_arr > 255) ? 8'd255 : 8'(m_arr);
    c2 = (m_arr > 3) ? 2'd3 : 2'(m_arr);
    return {ex, m_fault, c8, c2};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_det = 0; m_prev = 0; m_run = 0; m_high = 0;
    m_arr = 0; m_mode = 0; m_grn = 0; m_gap = 0; m_fault = 1'b0;
  endtask

  task automatic model_edge();
    int n_det, n_run, n_high, n_mode, n_grn, n_gap, nxt_gap;
    bit n_fault, green;
    green = (bus.cntry == 2'd2);
    n_det = m_det;
    n_run = 0;
    if (m_s2 != m_det) begin
      if (m_run == DEB) n_det = 1 - m_det;
      else n_run = m_run + 1;
    end
    if (m_det == 1 && m_prev == 0) m_arr++;
    if (m_det == 1) begin
      n_high  = (m_high < STUCK) ? m_high + 1 : STUCK;
      n_fault = (n_high == STUCK);
    end else begin
      n_high  = 0;
      n_fault = 1'b0;
    end
    n_mode = m_mode; n_grn = m_grn; n_gap = m_gap;
    case (m_mode)
      0: if (m_det == 1 || m_fault) n_mode = 1;
      1: if (green) begin n_mode = 2; n_grn = 0; n_gap = GAP; end
      2: begin
        nxt_gap = (m_det == 1 && !m_fault) ? GAP : m_gap - 1;
        if (!green || m_grn == MAXG - 1 || nxt_gap == 0) n_mode = 3;
        else begin n_grn = m_grn + 1; n_gap = nxt_gap; end
      end
      default: if (!green) n_mode = 0;
    endcase
    m_prev = m_det; m_s2 = m_s1; m_s1 = int'(bus.loop_raw);
    m_det = n_det; m_run = n_run; m_high = n_high; m_fault = n_fault;
    m_mode = n_mode; m_grn = n_grn; m_gap = n_gap;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    model_reset();
    #3;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.loop_raw = 1'b0;
    bus.cntry    = 2'd0;
    clr_n        = 1'b0;
    #2;
    checks++;
    if (dut_vec !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 12'h000);
    end
    do_reset();
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.cntry = 2'd0;
    for (int e = 0; e < 15; e++) begin
      bus.loop_raw = (e < 3);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL glitch e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({bus.x, bus.car_cnt} !== 9'h000) begin
      failures++;
      $display("FAIL glitch_final got x=%b cnt=%0d exp x=0 cnt=0", bus.x, bus.car_cnt);
    end
  endtask

  task automatic test_arrival();
    int rise, drop;
    do_reset();
    bus.cntry = 2'd0;
    bus.loop_raw = 1'b1;
    rise = -1;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL arrival_rise e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (rise < 0 && bus.x === 1'b1) rise = e;
    end
    checks++;
    if (rise != 3 + DEB) begin
      failures++;
      $display("FAIL arrival_latency got=%0d exp=%0d", rise, 3 + DEB);
    end
    checks++;
    if (bus.car_cnt !== 8'd1) begin
      failures++;
      $display("FAIL arrival_count got=%0d exp=1", bus.car_cnt);
    end
    bus.cntry = 2'd2;
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL arrival_serve e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
    end
    bus.loop_raw = 1'b0;
    drop = -1;
    for (int e = 0; e < 25; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL arrival_gap e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (drop < 0 && bus.x === 1'b0) drop = e;
    end
    checks++;
    if (drop < 0 || drop > 2 + DEB + GAP + 1) begin
      failures++;
      $display("FAIL arrival_gap_drop got=%0d exp<=%0d", drop, 2 + DEB + GAP + 1);
    end
    bus.cntry = 2'd1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (bus.x !== 1'b0 || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL arrival_idle e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_max_green();
    int hi, w;
    logic x0, x1;
    do_reset();
    bus.cntry = 2'd0;
    bus.loop_raw = 1'b1;
    w = 0;
    while (bus.x !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (bus.x !== 1'b1) begin
      failures++;
      $display("FAIL maxg_wait_x got=%b exp=1 (timeout)", bus.x);
    end
    bus.cntry = 2'd2;
    hi = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL maxg e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (bus.x === 1'b1) hi++;
    end
    checks++;
    if (hi != MAXG) begin
      failures++;
      $display("FAIL maxg_len got=%0d exp=%0d", hi, MAXG);
    end
    bus.cntry = 2'd1;
    tick();
    x0 = bus.x;
    tick();
    x1 = bus.x;
    checks++;
    if ({x0, x1} !== 2'b01) begin
      failures++;
      $display("FAIL maxg_rerequest got=%b%b exp=01", x0, x1);
    end
  endtask

  task automatic test_stuck();
    int fe, hi, ff;
    do_reset();
    bus.cntry = 2'd0;
    bus.loop_raw = 1'b1;
    fe = -1;
    for (int e = 0; e < 300; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stuck_on e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (fe < 0 && bus.fault === 1'b1) fe = e;
    end
    checks++;
    if (fe != 2 + DEB + STUCK) begin
      failures++;
      $display("FAIL stuck_set got=%0d exp=%0d", fe, 2 + DEB + STUCK);
    end
    bus.cntry = 2'd2;
    hi = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stuck_serve e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (bus.x === 1'b1) hi++;
    end
    checks++;
    if (hi != GAP) begin
      failures++;
      $display("FAIL stuck_gap got=%0d exp=%0d", hi, GAP);
    end
    bus.loop_raw = 1'b0;
    ff = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stuck_off e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (ff < 0 && bus.fault === 1'b0) ff = e;
    end
    checks++;
    if (ff != 3 + DEB) begin
      failures++;
      $display("FAIL stuck_clear got=%0d exp=%0d", ff, 3 + DEB);
    end
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    bus.cntry = 2'd0;
    for (int p = 0; p < 5; p++) begin
      for (int e = 0; e < 18; e++) begin
        bus.loop_raw = (e < 8) || (p == 4);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL midrst_pulse p=%0d e=%0d got=%h exp=%h", p, e, dut_vec, exp_vec());
        end
      end
    end
    bus.cntry = 2'd2;
    repeat (3) tick();
    checks++;
    if ({bus.x, bus.car_cnt} !== {1'b1, 8'd5}) begin
      failures++;
      $display("FAIL midrst_pre got x=%b cnt=%0d exp x=1 cnt=5", bus.x, bus.car_cnt);
    end
    #2;
    clr_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 12'h000) begin
      failures++;
      $display("FAIL midrst_async got=%h exp=%h", dut_vec, 12'h000);
    end
    model_reset();
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.cntry = 2'd0;
    for (int p = 0; p < 5; p++) begin
      for (int e = 0; e < 18; e++) begin
        bus.loop_raw = (e < 8);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL sat p=%0d e=%0d got=%h exp=%h", p, e, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if ({bus.car_cnt, bus2.car_cnt} !== {8'd5, 2'd3}) begin
      failures++;
      $display("FAIL sat_final got cnt8=%0d cnt2=%0d exp cnt8=5 cnt2=3", bus.car_cnt, bus2.car_cnt);
    end
  endtask

  task automatic test_random();
    int lhold, chold;
    do_reset();
    lhold = 0;
    chold = 0;
    for (int e = 0; e < 2500; e++) begin
      if (lhold == 0) begin
        bus.loop_raw = 1'($urandom_range(0, 1));
        lhold = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(1, 12));
      end
      if (chold == 0) begin
        bus.cntry = 2'($urandom_range(0, 3));
        chold = $urandom_range(1, 40);
      end
      lhold--;
      chold--;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_arrival();
    test_max_green();
    test_stuck();
    test_reset_mid_serve();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
